// File: rtl/addc_sample_capture.sv
// HSMC ADC capture: two-flop pin pipeline, rate divider, sample FIFO,
// Avalon-MM register slave and a registered sample/strobe output.
module addc_sample_capture #(
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 64,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    output logic [31:0]       avs_s0_readdata,
    input  logic [31:0]       avs_s0_writedata,
    input  logic [DATA_W-1:0] addc_hsmc_in,
    output logic [DATA_W-1:0] addc_data_out,
    output logic              addc_sample_tick
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] r_stage1;
    logic [DATA_W-1:0] r_stage2;
    logic [DATA_W-1:0] r_data_out;
    logic              r_sample_tick;
    logic              r_enable;
    logic              r_overflow;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_clear;
    logic              w_tick;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_accept;
    logic              w_ovf_set;
    logic [DATA_W-1:0] w_head;
    logic [15:0]       w_div16;
    logic [15:0]       w_count16;
    logic              w_unused;

    assign w_wr_ctrl   = avs_s0_write && (avs_s0_address == 2'd0);
    assign w_wr_status = avs_s0_write && (avs_s0_address == 2'd1);
    assign w_clear     = w_wr_ctrl && avs_s0_writedata[1];
    assign w_tick      = r_enable && (r_cnt == r_div);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_pop       = avs_s0_read && (avs_s0_address == 2'd2)
                         && !w_empty;
    // a clear in the same cycle as a tick discards that sample
    assign w_push      = w_tick && !w_clear;
    assign w_accept    = w_push && (!w_full || w_pop);
    assign w_ovf_set   = w_push && w_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_div16     = 16'(r_div);
    assign w_count16   = 16'(r_count);
    assign w_unused    = ^avs_s0_writedata[15:2];

    assign addc_data_out    = r_data_out;
    assign addc_sample_tick = r_sample_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= addc_hsmc_in;
            r_stage2 <= r_stage1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable <= 1'b0;
            r_div    <= '0;
            r_cnt    <= '0;
        end else if (w_wr_ctrl) begin
            r_enable <= avs_s0_writedata[0];
            r_div    <= avs_s0_writedata[16 +: DIV_W];
            r_cnt    <= '0;
        end else if (!r_enable || w_tick) begin
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out    <= '0;
            r_sample_tick <= 1'b0;
        end else begin
            r_sample_tick <= w_tick;
            if (w_tick) begin
                r_data_out <= r_stage2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= r_stage2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // a new overflow event wins over a same-cycle write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_wr_status && avs_s0_writedata[18]) begin
            r_overflow <= 1'b0;
        end
    end

    always_comb begin
        avs_s0_readdata = '0;
        if (avs_s0_read) begin
            unique case (avs_s0_address)
                2'd0: avs_s0_readdata = {w_div16, 14'b0, 1'b0, r_enable};
                2'd1: avs_s0_readdata = {13'b0, r_overflow, w_full,
                                         w_empty, w_count16};
                2'd2: avs_s0_readdata = w_empty ? 32'b0 : 32'(w_head);
                2'd3: avs_s0_readdata = 32'(r_data_out);
                default: avs_s0_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_addc_sample_capture.sv
// Bench for addc_sample_capture: directed phases plus a random phase,
// checked every cycle against a queue-based behavioural model.
module tb_addc_sample_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [13:0] pins;
    logic [13:0] dout;
    logic        stick;

    always #5 clk = ~clk;

    addc_sample_capture dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_address   (addr),
        .avs_s0_read      (rd),
        .avs_s0_write     (wr),
        .avs_s0_readdata  (rdata),
        .avs_s0_writedata (wdata),
        .addc_hsmc_in     (pins),
        .addc_data_out    (dout),
        .addc_sample_tick (stick)
    );

    int vecs = 0;
    int errs = 0;

    bit          m_en = 0;
    int          m_div = 0;
    int          m_since = 0;
    bit          m_ovf = 0;
    bit          m_tick = 0;
    logic [13:0] m_last = '0;
    logic [13:0] m_q[$];
    logic [13:0] m_hist[$] = '{14'h0, 14'h0};

    function automatic logic [31:0] exp_rd();
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = m_q.size();
        if (rd) begin
            case (addr)
                2'd0: v = {16'(m_div), 15'h0, m_en};
                2'd1: v = {13'h0, m_ovf, n == 64, n == 0, 16'(n)};
                2'd2: v = (n > 0) ? 32'(m_q[0]) : 32'h0;
                default: v = 32'(m_last);
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] a,
                        input logic rq, input logic wq,
                        input logic [31:0] wd, input logic [13:0] p,
                        input bit den = 0, input logic [31:0] dexp = 0);
        logic [13:0] s2;
        bit tk, pop, clr, push, set;
        reset = r; addr = a; rd = rq; wr = wq; wdata = wd; pins = p;
        #4;
        chk("readdata", rdata, exp_rd());
        if (den) chk("directed_rd", rdata, dexp);
        tk = m_en && ((m_since % (m_div + 1)) == m_div);
        s2 = m_hist[m_hist.size() - 2];
        @(posedge clk);
        if (r) begin
            m_en = 0; m_div = 0; m_since = 0; m_ovf = 0;
            m_tick = 0; m_last = '0;
            m_q.delete();
            m_hist = '{14'h0, 14'h0};
        end else begin
            pop  = rq && (a == 2'd2) && (m_q.size() > 0);
            clr  = wq && (a == 2'd0) && wd[1];
            push = tk && !clr;
            set  = 0;
            if (clr) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    if (m_q.size() < 64) m_q.push_back(s2);
                    else set = 1;
                end
            end
            if (clr) m_ovf = 0;
            else if (set) m_ovf = 1;
            else if (wq && (a == 2'd1) && wd[18]) m_ovf = 0;
            if (tk) m_last = s2;
            m_tick = tk;
            if (wq && (a == 2'd0)) begin
                m_en = wd[0]; m_div = int'(wd[31:16]); m_since = 0;
            end else if (m_en) begin
                m_since++;
            end
            m_hist.push_back(p);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
        end
        #1;
        chk("data_out", 32'(dout), 32'(m_last));
        chk("sample_tick", 32'(stick), 32'(m_tick));
    endtask

    initial begin
        logic [31:0] w;
        int k;
        reset = 1'b1; addr = '0; rd = 0; wr = 0; wdata = '0; pins = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 32'h0001_0000);
        step(0, 2, 1, 0, 0, 0, 1, 32'h0);
        step(0, 3, 1, 0, 0, 0, 1, 32'h0);
        step(0, 0, 1, 0, 0, 0, 1, 32'h0);

        step(0, 0, 0, 1, 32'h0003_0001, 14'h1A5);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 14'h1A5);
        step(0, 0, 0, 1, 32'h0, 14'h1A5);
        step(0, 1, 1, 0, 0, 14'h1A5, 1, 32'h0000_0003);
        for (int i = 0; i < 3; i++)
            step(0, 2, 1, 0, 0, 14'h1A5, 1, 32'h0000_01A5);
        step(0, 1, 1, 0, 0, 14'h1A5, 1, 32'h0001_0000);

        step(0, 0, 0, 1, 32'h0000_0003, 0);
        for (int i = 1; i <= 24; i++) step(0, 2, 1, 0, 0, 14'(i));

        step(0, 0, 0, 1, 32'h0000_0003, 14'($urandom));
        for (int i = 0; i < 70; i++) step(0, 0, 0, 0, 0, 14'($urandom));
        step(0, 0, 0, 1, 32'h0, 14'($urandom));
        step(0, 1, 1, 0, 0, 0, 1, 32'h0006_0040);
        step(0, 1, 0, 1, 32'h0004_0000, 0);
        step(0, 1, 1, 0, 0, 0, 1, 32'h0002_0040);
        step(0, 2, 1, 0, 0, 0);

        step(0, 0, 0, 1, 32'h0000_0001, 14'($urandom));
        step(0, 0, 0, 0, 0, 14'($urandom));
        for (int i = 0; i < 10; i++) step(0, 2, 1, 0, 0, 14'($urandom));
        step(0, 1, 1, 0, 0, 0, 1, 32'h0002_0040);

        step(0, 0, 0, 1, 32'h0000_0003, 14'($urandom));
        step(0, 1, 1, 0, 0, 0, 1, 32'h0001_0000);

        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 7));
            w = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                step(1, 0, 0, 0, 0, 14'(w));
            end else begin
                case (k)
                    3: step(0, 2'(w >> 20), 1, 0, 0, 14'(w));
                    4: step(0, 2, 1, 0, 0, 14'(w));
                    5: begin
                        w[31:16] = 16'($urandom_range(0, 3));
                        w[1] = ($urandom_range(0, 3) == 0);
                        w[0] = ($urandom_range(0, 3) != 0);
                        step(0, 0, 0, 1, w, 14'(w));
                    end
                    6: step(0, 1, 0, 1, w, 14'(w));
                    7: step(0, 2'(2 + (w & 1)), 0, 1, w, 14'(w));
                    default: step(0, 0, 0, 0, 0, 14'(w));
                endcase
            end
        end

        step(0, 0, 0, 1, 32'h0001_0001, 14'h2AB);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 14'($urandom));
        step(1, 0, 0, 0, 0, 14'($urandom));
        step(0, 0, 1, 0, 0, 0, 1, 32'h0);
        step(0, 1, 1, 0, 0, 0, 1, 32'h0001_0000);
        step(0, 3, 1, 0, 0, 0, 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
